// File: rtl/char_pkg.sv
// char_pkg
//   Definitions shared by char_min_select and the downstream judge stage:
//   the selector state type, the default template-set geometry and the
//   all-ones difference value that marks "no result" / "ambiguous".
package char_pkg;

   localparam int unsigned NUM_TMPL_DEF = 10;
   localparam int unsigned IDX_W_DEF    = 4;
   localparam int unsigned DIFF_W_DEF   = 16;

   localparam logic [DIFF_W_DEF-1:0] DIFF_MAX = '1;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      EMIT
   } state_t;

endpackage

// File: rtl/char_min_select_sat_acc.sv
// sat_acc
//   Saturating accumulator: adds an unsigned PART_W value into a DIFF_W
//   register, clamping at all-ones instead of wrapping.
//   Ports:
//     clk, rst  clock, asynchronous active-high reset
//     clr       synchronous clear (priority over en)
//     en        load acc with sum this cycle
//     din       value to add
//     acc       registered accumulator
//     sum       combinational sat(acc + din), usable without loading it
module sat_acc #(
   parameter int unsigned PART_W = 8,
   parameter int unsigned DIFF_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [PART_W-1:0] din,
   output logic [DIFF_W-1:0] acc,
   output logic [DIFF_W-1:0] sum
);

   logic [DIFF_W:0] ext;

   always_comb begin
      ext = {1'b0, acc} + {{(DIFF_W + 1 - PART_W){1'b0}}, din};
      sum = ext[DIFF_W] ? '1 : ext[DIFF_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= sum;
      end
   end

endmodule

// File: rtl/char_min_select.sv
// char_min_select
//   Accumulates streamed partial mismatch counts per template for one
//   character, keeps the minimum-difference template and emits it as a
//   one-cycle char_valid pulse for the judge stage.
//   Optional feature (macro CHAR_MIN_MARGIN_EN): tracks the runner-up and
//   forces char_diff to all-ones (ambig = 1) when best and runner-up are
//   closer than MARGIN.
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     clr         synchronous abort of the character in progress
//     part_cnt    partial mismatch count beat
//     part_valid  beat qualifier (no backpressure)
//     tmpl_last   last beat of current template
//     char_last   last beat of last template
//     char_index  best template index        (held between emits)
//     char_diff   best accumulated difference (held between emits)
//     char_valid  one-cycle result pulse
//     ambig       result ambiguous (only with CHAR_MIN_MARGIN_EN)
//     tmpl_err    sticky template-count error
module char_min_select
   import char_pkg::*;
#(
   parameter int unsigned NUM_TMPL = NUM_TMPL_DEF,
   parameter int unsigned IDX_W    = IDX_W_DEF,
   parameter int unsigned PART_W   = 8,
   parameter int unsigned DIFF_W   = DIFF_W_DEF,
   parameter int unsigned MARGIN   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [PART_W-1:0] part_cnt,
   input  logic              part_valid,
   input  logic              tmpl_last,
   input  logic              char_last,
   output logic [IDX_W-1:0]  char_index,
   output logic [DIFF_W-1:0] char_diff,
   output logic              char_valid,
`ifdef CHAR_MIN_MARGIN_EN
   output logic              ambig,
`endif
   output logic              tmpl_err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TMPL - 1);

   state_t            state;
   logic [DIFF_W-1:0] acc;
   logic [DIFF_W-1:0] fsum;
   logic [DIFF_W-1:0] best_diff;
   logic [IDX_W-1:0]  best_idx;
   logic [IDX_W-1:0]  tmpl_cnt;

   logic              close;
   logic              in_range;
   logic [DIFF_W-1:0] best_nx;
   logic [IDX_W-1:0]  idx_nx;
   logic [DIFF_W-1:0] emit_diff;
   logic              err_nx;
`ifdef CHAR_MIN_MARGIN_EN
   localparam logic [DIFF_W-1:0] MARGIN_W = DIFF_W'(MARGIN);
   logic [DIFF_W-1:0] second_diff;
   logic [DIFF_W-1:0] second_nx;
   logic              ambig_nx;
`endif

   // Accumulator clears at each template close so the next beat starts a
   // fresh template; fsum is the closing template's final total.
   sat_acc #(
      .PART_W (PART_W),
      .DIFF_W (DIFF_W)
   ) u_acc (
      .clk (clk),
      .rst (rst),
      .clr (clr | close),
      .en  (part_valid),
      .din (part_cnt),
      .acc (acc),
      .sum (fsum)
   );

   always_comb begin
      close    = part_valid & (tmpl_last | char_last);
      in_range = (tmpl_cnt <= LAST_IDX);
      best_nx  = best_diff;
      idx_nx   = best_idx;
`ifdef CHAR_MIN_MARGIN_EN
      second_nx = second_diff;
`endif
      if (close && in_range) begin
         if (fsum < best_diff) begin
            best_nx = fsum;
            idx_nx  = tmpl_cnt;
`ifdef CHAR_MIN_MARGIN_EN
            second_nx = best_diff;
`endif
         end
`ifdef CHAR_MIN_MARGIN_EN
         else if (fsum < second_diff) begin
            second_nx = fsum;
         end
`endif
      end
      err_nx = tmpl_err
             | (close & ~in_range)
             | (part_valid & char_last & (tmpl_cnt != LAST_IDX));
      emit_diff = best_nx;
`ifdef CHAR_MIN_MARGIN_EN
      ambig_nx = ((second_nx - best_nx) < MARGIN_W);
      if (ambig_nx) begin
         emit_diff = '1;
      end
`endif
   end

   // The result is captured from the char_last beat itself and the tracking
   // registers are re-armed on that same edge, so the EMIT cycle already
   // sees a clean template-0 context for a back-to-back next character.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         best_diff  <= '1;
         best_idx   <= '0;
         tmpl_cnt   <= '0;
         char_index <= '0;
         char_diff  <= '0;
         char_valid <= 1'b0;
         tmpl_err   <= 1'b0;
`ifdef CHAR_MIN_MARGIN_EN
         second_diff <= '1;
         ambig       <= 1'b0;
`endif
      end else if (clr) begin
         state      <= IDLE;
         best_diff  <= '1;
         best_idx   <= '0;
         tmpl_cnt   <= '0;
         char_valid <= 1'b0;
         tmpl_err   <= 1'b0;
`ifdef CHAR_MIN_MARGIN_EN
         second_diff <= '1;
         ambig       <= 1'b0;
`endif
      end else begin
         char_valid <= 1'b0;
         tmpl_err   <= err_nx;
`ifdef CHAR_MIN_MARGIN_EN
         ambig <= 1'b0;
`endif
         case (state)
            IDLE:    if (part_valid) state <= char_last ? EMIT : ACC;
            ACC:     if (part_valid && char_last) state <= EMIT;
            EMIT:    state <= part_valid ? (char_last ? EMIT : ACC) : IDLE;
            default: state <= IDLE;
         endcase

         if (part_valid && char_last) begin
            char_valid <= 1'b1;
            char_index <= idx_nx;
            char_diff  <= emit_diff;
            best_diff  <= '1;
            best_idx   <= '0;
            tmpl_cnt   <= '0;
`ifdef CHAR_MIN_MARGIN_EN
            ambig       <= ambig_nx;
            second_diff <= '1;
`endif
         end else if (close) begin
            best_diff <= best_nx;
            best_idx  <= idx_nx;
            if (tmpl_cnt != '1) begin
               tmpl_cnt <= tmpl_cnt + 1'b1;
            end
`ifdef CHAR_MIN_MARGIN_EN
            second_diff <= second_nx;
`endif
         end
      end
   end

endmodule

// File: tb/tb_char_min_select.sv
module tb_char_min_select;
   import char_pkg::*;

   localparam int unsigned NT  = 10;
   localparam int unsigned PW  = 8;
   localparam int unsigned DW  = 16;
   localparam int unsigned IW  = 4;
   localparam int unsigned MRG = 8;
   localparam int unsigned DMAX = 65535;

   logic          clk = 1'b0;
   logic          rst;
   logic          clr;
   logic [PW-1:0] part_cnt;
   logic          part_valid;
   logic          tmpl_last;
   logic          char_last;
   logic [IW-1:0] char_index;
   logic [DW-1:0] char_diff;
   logic          char_valid;
   logic          tmpl_err;
`ifdef CHAR_MIN_MARGIN_EN
   logic          ambig;
`endif

   char_min_select #(
      .NUM_TMPL (NT),
      .IDX_W    (IW),
      .PART_W   (PW),
      .DIFF_W   (DW),
      .MARGIN   (MRG)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .part_cnt   (part_cnt),
      .part_valid (part_valid),
      .tmpl_last  (tmpl_last),
      .char_last  (char_last),
      .char_index (char_index),
      .char_diff  (char_diff),
      .char_valid (char_valid),
`ifdef CHAR_MIN_MARGIN_EN
      .ambig      (ambig),
`endif
      .tmpl_err   (tmpl_err)
   );

   typedef struct {
      int unsigned idx;
      int unsigned diff;
      bit          err;
      bit          amb;
      int unsigned cyc;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned bv[16][320];
   int unsigned nb[16];
   int unsigned ntmpl;
   bit          err_model;
   int unsigned cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Monitor: every char_valid pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (!rst && char_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_char_valid", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("char_index", char_index, e.idx);
            chk("char_diff", char_diff, e.diff);
            chk("tmpl_err", tmpl_err, e.err);
            chk("latency_cycle", cyc, e.cyc);
`ifdef CHAR_MIN_MARGIN_EN
            chk("ambig", ambig, e.amb);
`endif
         end
      end
   end

   task automatic drive_beat(input int unsigned v, input bit tl, input bit cl);
      @(posedge clk);
      #1;
      part_valid = 1'b1;
      part_cnt   = PW'(v);
      tmpl_last  = tl;
      char_last  = cl;
   endtask

   task automatic idle_beat();
      @(posedge clk);
      #1;
      part_valid = 1'b0;
      part_cnt   = PW'($urandom);
      tmpl_last  = 1'($urandom);
      char_last  = 1'($urandom);
   endtask

   task automatic set_tmpl(input int t, input int unsigned total, input int unsigned n);
      for (int unsigned b = 0; b < n; b++)
         bv[t][b] = total / n + ((b == 0) ? total % n : 0);
      nb[t] = n;
   endtask

   task automatic set_rep(input int t, input int unsigned v, input int unsigned n);
      for (int unsigned b = 0; b < n; b++) bv[t][b] = v;
      nb[t] = n;
   endtask

   task automatic do_clr();
      @(posedge clk);
      #1;
      part_valid = 1'b0;
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      err_model = 1'b0;
   endtask

   // Reference: per-template totals clamp at DMAX; strict minimum over
   // templates 0..NT-1 starting from an all-ones best; count mismatch flags.
   task automatic send_char(input int unsigned gap_max);
      exp_t        e;
      int unsigned best, second, idx, s;
      bit          err;
      best = DMAX; second = DMAX; idx = 0; err = 0;
      for (int unsigned t = 0; t < ntmpl; t++) begin
         s = 0;
         for (int unsigned b = 0; b < nb[t]; b++) s += bv[t][b];
         if (s > DMAX) s = DMAX;
         if (t >= NT) err = 1;
         else if (s < best) begin second = best; best = s; idx = t; end
         else if (s < second) second = s;
      end
      if (ntmpl != NT) err = 1;
      err_model = err_model | err;
      e.idx = idx; e.diff = best; e.err = err_model; e.cyc = 0;
      e.amb = (second - best) < MRG;
`ifdef CHAR_MIN_MARGIN_EN
      if (e.amb) e.diff = DMAX;
`endif
      exp_q.push_back(e);
      for (int unsigned t = 0; t < ntmpl; t++) begin
         for (int unsigned b = 0; b < nb[t]; b++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) idle_beat();
            drive_beat(bv[t][b], b == nb[t] - 1, (t == ntmpl - 1) && (b == nb[t] - 1));
         end
      end
      exp_q[exp_q.size() - 1].cyc = cyc + 1;
   endtask

   task automatic fill_flat(input int unsigned n, input int unsigned v);
      ntmpl = n;
      for (int t = 0; t < 16; t++) set_tmpl(t, v, 2);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; part_valid = 1'b0; part_cnt = '0;
      tmpl_last = 1'b0; char_last = 1'b0; err_model = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_char_valid", char_valid, 0);
      chk("reset_char_index", char_index, 0);
      chk("reset_char_diff", char_diff, 0);
      chk("reset_tmpl_err", tmpl_err, 0);

      // Single minimum.
      fill_flat(10, 100); set_tmpl(5, 20, 2);
      send_char(0);
      idle_beat();
      // Tie keeps lower index.
      fill_flat(10, 90); set_tmpl(3, 40, 2); set_tmpl(7, 40, 2);
      send_char(1);
      // Saturation: no wrap-around of the 300x255 template.
      ntmpl = 10;
      for (int t = 0; t < 10; t++) set_rep(t, 255, 270);
      set_rep(2, 255, 300); set_rep(9, 255, 257);
      send_char(0);
      idle_beat();
      // Margin cases (plain minimum when the feature is off).
      fill_flat(10, 200); set_tmpl(4, 50, 2); set_tmpl(8, 55, 2);
      send_char(0);
      fill_flat(10, 200); set_tmpl(4, 50, 2); set_tmpl(8, 60, 2);
      send_char(0);
      idle_beat();
      // Too few templates.
      fill_flat(8, 120); set_tmpl(6, 33, 2);
      send_char(0);
      repeat (3) idle_beat();
      chk("tmpl_err_sticky", tmpl_err, 1);
      do_clr();
      @(negedge clk);
      chk("tmpl_err_after_clr", tmpl_err, 0);

      // clr in the middle of template 4, then a clean character.
      for (int t = 0; t < 4; t++) begin
         drive_beat(0, 0, 0); drive_beat(0, 1, 0);
      end
      drive_beat(1, 0, 0);
      do_clr();
      fill_flat(10, 100); set_tmpl(6, 30, 2);
      send_char(0);
      repeat (3) idle_beat();

      // Asynchronous reset in the middle of a character.
      for (int t = 0; t < 4; t++) begin
         drive_beat(0, 0, 0); drive_beat(0, 1, 0);
      end
      drive_beat(1, 0, 0);
      #2 rst = 1'b1;
      #3 rst = 1'b0;
      err_model = 1'b0;
      @(negedge clk);
      chk("rst_mid_char_diff", char_diff, 0);
      chk("rst_mid_char_valid", char_valid, 0);
      fill_flat(10, 100); set_tmpl(6, 30, 2);
      send_char(0);

      // Randomized characters, including back-to-back and miscounted ones.
      for (int k = 0; k < 40; k++) begin
         ntmpl = ($urandom_range(0, 5) == 0) ? $urandom_range(2, 12) : 10;
         for (int t = 0; t < 16; t++) begin
            nb[t] = $urandom_range(1, 4);
            for (int unsigned b = 0; b < nb[t]; b++) bv[t][b] = $urandom_range(0, 255);
         end
         send_char($urandom_range(0, 2));
         if ($urandom_range(0, 7) == 0) do_clr();
         else if ($urandom_range(0, 1) == 0) idle_beat();
      end
      idle_beat();

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
